regfile_mp: RTL and testbench

- Parametrised multi-port register file; successor to the single-cycle CPU register memory.
- Provides two combinational read ports and two write ports, with write-to-read bypass.
- Includes a sequential bulk-clear engine so software and the pipeline controller can zero the file without a reset.
- Sits between decode (read addresses) and writeback (write ports) in the pipelined core.

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 tb/tb_regfile_mp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: two combinational read ports with write bypass, two write ports,
// and a sequential bulk-clear engine. Optional macro: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en_0,
  input  logic [ADDR_W-1:0] wr_addr_0,
  input  logic [DATA_W-1:0] wr_data_0,
  input  logic              wr_en_1,
  input  logic [ADDR_W-1:0] wr_addr_1,
  input  logic [DATA_W-1:0] wr_data_1,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              wr_dropped,
  output logic              dbg_clear_state
);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            r_state, w_next_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_idx, w_idx_next;
  logic              r_done, r_dropped;
  logic              w_done_next, w_clear_we, w_busy;
  logic              w_we0, w_we1, w_drop;
  logic [ADDR_W-1:0] w_ra [2];
  logic [DATA_W-1:0] w_rd [2];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign w_busy = (r_state == S_CLEAR);

`ifdef REGFILE_ZERO_REG_EN
  // Address 0 is a legal target but never stored, so it is not counted as dropped.
  assign w_we0 = wr_en_0 && in_range(wr_addr_0) && (wr_addr_0 != '0) && !w_busy;
  assign w_we1 = wr_en_1 && in_range(wr_addr_1) && (wr_addr_1 != '0) && !w_busy;
`else
  assign w_we0 = wr_en_0 && in_range(wr_addr_0) && !w_busy;
  assign w_we1 = wr_en_1 && in_range(wr_addr_1) && !w_busy;
`endif

  assign w_drop = w_busy ? (wr_en_0 || wr_en_1)
                         : ((wr_en_0 && !in_range(wr_addr_0)) || (wr_en_1 && !in_range(wr_addr_1)));

  assign w_ra[0] = rd_addr_a;
  assign w_ra[1] = rd_addr_b;

  // Port 1 bypass takes priority, matching the write-collision rule on the array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = '0;
      if (in_range(w_ra[p])) begin
        if (w_we1 && (w_ra[p] == wr_addr_1))      w_rd[p] = wr_data_1;
        else if (w_we0 && (w_ra[p] == wr_addr_0)) w_rd[p] = wr_data_0;
        else                                      w_rd[p] = r_mem[w_ra[p]];
      end
    end
  end

  assign rd_data_a = w_rd[0];
  assign rd_data_b = w_rd[1];

  always_comb begin
    w_next_state = r_state;
    w_idx_next   = r_idx;
    w_clear_we   = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clear_req) begin
          w_next_state = S_CLEAR;
          w_idx_next   = '0;
        end
      end
      S_CLEAR: begin
        w_clear_we = 1'b1;
        if (r_idx == ADDR_W'(DEPTH - 1)) begin
          w_next_state = S_IDLE;
          w_done_next  = 1'b1;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_idx     <= w_idx_next;
      r_done    <= w_done_next;
      r_dropped <= w_drop;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_we0)      r_mem[wr_addr_0] <= wr_data_0;
      if (w_we1)      r_mem[wr_addr_1] <= wr_data_1;
      if (w_clear_we) r_mem[r_idx]     <= '0;
    end
  end

  assign clear_busy      = w_busy;
  assign clear_done      = r_done;
  assign wr_dropped      = r_dropped;
  assign dbg_clear_state = r_state;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, collisions, out-of-range, bulk clear, reset mid-clear.
module tb_regfile_mp;

  logic        clock, reset;
  logic [4:0]  rd_addr_a, rd_addr_b, wr_addr_0, wr_addr_1;
  logic [31:0] rd_data_a, rd_data_b, wr_data_0, wr_data_1;
  logic        wr_en_0, wr_en_1, clear_req, clear_busy, clear_done, wr_dropped, dbg_state;

  logic [4:0]  s_rd_addr_a, s_rd_addr_b, s_wr_addr_0, s_wr_addr_1;
  logic [31:0] s_rd_data_a, s_rd_data_b, s_wr_data_0, s_wr_data_1;
  logic        s_wr_en_0, s_wr_en_1, s_clear_req, s_clear_busy, s_clear_done, s_wr_dropped, s_dbg_state;

  int vectors = 0;
  int errors  = 0;
  int busy_cnt, done_cnt;

  regfile_mp u_dut (
    .clock(clock), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en_0(wr_en_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0),
    .wr_en_1(wr_en_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
    .wr_dropped(wr_dropped), .dbg_clear_state(dbg_state)
  );

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(24)) u_small (
    .clock(clock), .reset(reset),
    .rd_addr_a(s_rd_addr_a), .rd_addr_b(s_rd_addr_b),
    .rd_data_a(s_rd_data_a), .rd_data_b(s_rd_data_b),
    .wr_en_0(s_wr_en_0), .wr_addr_0(s_wr_addr_0), .wr_data_0(s_wr_data_0),
    .wr_en_1(s_wr_en_1), .wr_addr_1(s_wr_addr_1), .wr_data_1(s_wr_data_1),
    .clear_req(s_clear_req), .clear_busy(s_clear_busy), .clear_done(s_clear_done),
    .wr_dropped(s_wr_dropped), .dbg_clear_state(s_dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0;
    wr_en_0 = 0; wr_addr_0 = '0; wr_data_0 = '0;
    wr_en_1 = 0; wr_addr_1 = '0; wr_data_1 = '0;
    clear_req = 0;
    s_rd_addr_a = '0; s_rd_addr_b = '0;
    s_wr_en_0 = 0; s_wr_addr_0 = '0; s_wr_data_0 = '0;
    s_wr_en_1 = 0; s_wr_addr_1 = '0; s_wr_data_1 = '0;
    s_clear_req = 0;

    // Reset state
    rd_addr_a = 5'd3;
    #2;
    check("rst_rd_during", rd_data_a, 32'h0);
    check("rst_busy_during", {31'b0, clear_busy}, 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #1;
      check("rst_rd_a", rd_data_a, 32'h0);
      check("rst_rd_b", rd_data_b, 32'h0);
    end
    check("rst_busy", {31'b0, clear_busy}, 32'h0);
    check("rst_done", {31'b0, clear_done}, 32'h0);
    check("rst_drop", {31'b0, wr_dropped}, 32'h0);
    check("rst_state", {31'b0, dbg_state}, 32'h0);

    // Same-cycle bypass on port 0, then stored value
    wr_en_0 = 1; wr_addr_0 = 5'd5; wr_data_0 = 32'hDEADBEEF; rd_addr_a = 5'd5;
    #1;
    check("byp_r5_same", rd_data_a, 32'hDEADBEEF);
    tick();
    wr_en_0 = 0;
    #1;
    check("byp_r5_next", rd_data_a, 32'hDEADBEEF);
    check("byp_r5_nodrop", {31'b0, wr_dropped}, 32'h0);

    // Collision on r7: port 1 wins
    wr_en_0 = 1; wr_addr_0 = 5'd7; wr_data_0 = 32'h1111;
    wr_en_1 = 1; wr_addr_1 = 5'd7; wr_data_1 = 32'h2222;
    rd_addr_b = 5'd7;
    #1;
    check("coll_r7_byp", rd_data_b, 32'h2222);
    tick();
    wr_en_0 = 0; wr_en_1 = 0;
    #1;
    check("coll_r7_store", rd_data_b, 32'h2222);

    // Out-of-range on a 24-entry instance
    s_wr_en_0 = 1; s_wr_addr_0 = 5'd30; s_wr_data_0 = 32'h5; s_rd_addr_a = 5'd30;
    #1;
    check("oor_rd_same", s_rd_data_a, 32'h0);
    tick();
    s_wr_en_0 = 0;
    #1;
    check("oor_drop", {31'b0, s_wr_dropped}, 32'h1);
    check("oor_rd_next", s_rd_data_a, 32'h0);
    s_wr_en_1 = 1; s_wr_addr_1 = 5'd23; s_wr_data_1 = 32'h23; s_rd_addr_a = 5'd23;
    #1;
    check("edge23_byp", s_rd_data_a, 32'h23);
    tick();
    s_wr_en_1 = 0;
    #1;
    check("edge23_nodrop", {31'b0, s_wr_dropped}, 32'h0);
    check("edge23_store", s_rd_data_a, 32'h23);

    // Fill r0..r31 with index
    for (int i = 0; i < 32; i++) begin
      wr_en_0 = 1; wr_addr_0 = 5'(i); wr_data_0 = 32'(i);
      tick();
    end
    wr_en_0 = 0;
    rd_addr_a = 5'd17; rd_addr_b = 5'd31;
    #1;
    check("fill_r17", rd_data_a, 32'd17);
    check("fill_r31", rd_data_b, 32'd31);

    // Bulk clear with a dropped write to r3 on its second cycle
    clear_req = 1;
    tick();
    clear_req = 0;
    check("clr_state", {31'b0, dbg_state}, 32'h1);
    busy_cnt = 0; done_cnt = 0;
    while (clear_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 2) begin
        rd_addr_a = 5'd3; wr_en_0 = 1; wr_addr_0 = 5'd3; wr_data_0 = 32'hAA;
        #1;
        check("clr_nobypass_r3", rd_data_a, 32'd3);
      end
      if (busy_cnt == 5) begin
        rd_addr_a = 5'd0; rd_addr_b = 5'd20;
        #1;
        check("clr_mid_r0", rd_data_a, 32'd0);
        check("clr_mid_r20", rd_data_b, 32'd20);
      end
      tick();
      if (busy_cnt == 2) begin
        wr_en_0 = 0;
        check("clr_drop", {31'b0, wr_dropped}, 32'h1);
      end
      if (busy_cnt == 3) check("clr_drop_end", {31'b0, wr_dropped}, 32'h0);
      if (clear_done) done_cnt++;
    end
    tick();
    if (clear_done) done_cnt++;
    check("clr_busy_cycles", 32'(busy_cnt), 32'd32);
    check("clr_done_pulses", 32'(done_cnt), 32'd1);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      #1;
      check("clr_after", rd_data_a, 32'h0);
    end

    // Write in the clear_req cycle commits, then is cleared; clear_req during CLEAR is ignored
    wr_en_1 = 1; wr_addr_1 = 5'd9; wr_data_1 = 32'h99; clear_req = 1; rd_addr_a = 5'd9;
    tick();
    wr_en_1 = 0; clear_req = 0;
    #1;
    check("req_wr_commit", rd_data_a, 32'h99);
    check("req_busy", {31'b0, clear_busy}, 32'h1);
    busy_cnt = 0;
    while (clear_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 10) clear_req = 1;
      tick();
      clear_req = 0;
    end
    check("req_ignored_cycles", 32'(busy_cnt), 32'd32);
    check("req_r9_cleared", rd_data_a, 32'h0);
    tick();
    check("req_no_restart", {31'b0, clear_busy}, 32'h0);

    // Reset asserted mid-clear
    wr_en_0 = 1; wr_addr_0 = 5'd12; wr_data_0 = 32'h1234;
    tick();
    wr_en_0 = 0;
    clear_req = 1;
    tick();
    clear_req = 0;
    repeat (9) tick();
    check("mc_busy_before", {31'b0, clear_busy}, 32'h1);
    reset = 1'b0;
    #1;
    check("mc_busy_now", {31'b0, clear_busy}, 32'h0);
    rd_addr_a = 5'd12;
    #1;
    check("mc_r12", rd_data_a, 32'h0);
    done_cnt = 0;
    repeat (2) begin tick(); if (clear_done) done_cnt++; end
    reset = 1'b1;
    repeat (3) begin tick(); if (clear_done) done_cnt++; end
    check("mc_no_done", 32'(done_cnt), 32'd0);
    check("mc_busy_after", {31'b0, clear_busy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_b = 5'(i);
      #1;
      check("mc_after", rd_data_b, 32'h0);
    end

    // Address 0 behaviour
    wr_en_1 = 1; wr_addr_1 = 5'd0; wr_data_1 = 32'hFFFF; rd_addr_a = 5'd0;
    #1;
`ifdef REGFILE_ZERO_REG_EN
    check("r0_same", rd_data_a, 32'h0);
`else
    check("r0_same", rd_data_a, 32'hFFFF);
`endif
    tick();
    wr_en_1 = 0;
    #1;
`ifdef REGFILE_ZERO_REG_EN
    check("r0_next", rd_data_a, 32'h0);
`else
    check("r0_next", rd_data_a, 32'hFFFF);
`endif
    check("r0_nodrop", {31'b0, wr_dropped}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
